// File: rtl/pc_fetch_stage.sv
// MIPS instruction-fetch stage: owns the PC, runs the imem request handshake
// and loads the IF/ID register, with stall, redirect flush and stale-fetch discard.
module pc_fetch_stage #(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter logic [31:0] NOP_INSTR = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        stall,
  input  logic        jump_taken,
  input  logic [31:0] jump_dir,
  input  logic        branch_taken,
  input  logic [31:0] branch_dir,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ready,
  input  logic [31:0] imem_rdata,
  output logic [31:0] pc,
  output logic [31:0] if_id_instr,
  output logic [31:0] if_id_pc4,
  output logic        if_id_valid
);

  localparam logic [1:0] FETCH   = 2'd0;
  localparam logic [1:0] HOLD    = 2'd1;
  localparam logic [1:0] DISCARD = 2'd2;

  logic [1:0]  state;
  logic [31:0] req_addr;
  logic [31:0] hold_instr;
  logic [31:0] hold_pc4;
  logic        redirect;
  logic [31:0] target;
  logic [31:0] pc_plus4;

  // The branch in EX is older than the jump in ID, so it takes priority.
  assign redirect = branch_taken | jump_taken;
  assign target   = branch_taken ? branch_dir : jump_dir;
  assign pc_plus4 = pc + 32'd4;

  // A request abandoned by a redirect keeps its address until memory answers it.
  assign imem_req  = rst_n && (state != HOLD);
  assign imem_addr = (state == DISCARD) ? req_addr : pc;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= FETCH;
      pc          <= RESET_PC;
      req_addr    <= RESET_PC;
      hold_instr  <= NOP_INSTR;
      hold_pc4    <= 32'd0;
      if_id_instr <= NOP_INSTR;
      if_id_pc4   <= 32'd0;
      if_id_valid <= 1'b0;
    end else begin
      case (state)
        FETCH: begin
          if (redirect) begin
            pc          <= target;
            if_id_valid <= 1'b0;
            if_id_instr <= NOP_INSTR;
            if (!imem_ready) begin
              req_addr <= pc;
              state    <= DISCARD;
            end
          end else if (imem_ready && !stall) begin
            if_id_instr <= imem_rdata;
            if_id_pc4   <= pc_plus4;
            if_id_valid <= 1'b1;
            pc          <= pc_plus4;
          end else if (imem_ready) begin
            hold_instr <= imem_rdata;
            hold_pc4   <= pc_plus4;
            state      <= HOLD;
          end else if (!stall) begin
            if_id_valid <= 1'b0;
            if_id_instr <= NOP_INSTR;
          end
        end

        HOLD: begin
          if (redirect) begin
            pc          <= target;
            if_id_valid <= 1'b0;
            if_id_instr <= NOP_INSTR;
            state       <= FETCH;
          end else if (!stall) begin
            if_id_instr <= hold_instr;
            if_id_pc4   <= hold_pc4;
            if_id_valid <= 1'b1;
            pc          <= pc_plus4;
            state       <= FETCH;
          end
        end

        DISCARD: begin
          if_id_valid <= 1'b0;
          if_id_instr <= NOP_INSTR;
          if (redirect) begin
            pc <= target;
          end
          if (imem_ready) begin
            state <= FETCH;
          end
        end

        default: begin
          state <= FETCH;
        end
      endcase
    end
  end

endmodule

// File: doc/pc_fetch_stage.md
Name: pc_fetch_stage

Overview:
- Instruction-fetch stage of the MIPS pipeline, upstream of ID.
- Holds the PC and drives the instruction-memory request handshake.
- Consumes the resolved jump target from the jump/JR address mux (ID) and the branch target from EX.
- Produces the IF/ID pipeline register: instruction, PC+4 and a valid bit. Supports stall, flush-on-redirect and discard of in-flight fetches.

Parameters:
- RESET_PC, 32'h0000_0000, PC value loaded on reset.
- NOP_INSTR, 32'h0000_0000, instruction word driven into IF/ID when invalid/flushed (sll $0,$0,0).

Ports:
- clk  in  1  pipeline clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- stall  in  1  hazard unit: ID not accepting; hold PC and IF/ID.
- jump_taken  in  1  ID decoded J/JAL/JR this cycle.
- jump_dir  in  32  jump target (jump/JR mux output).
- branch_taken  in  1  EX resolved a taken branch.
- branch_dir  in  32  branch target from EX.
- imem_req  out  1  fetch request; held until imem_ready.
- imem_addr  out  32  fetch address; stable while imem_req=1.
- imem_ready  in  1  memory returns imem_rdata this cycle.
- imem_rdata  in  32  fetched instruction.
- pc  out  32  current fetch PC.
- if_id_instr  out  32  IF/ID instruction.
- if_id_pc4  out  32  IF/ID PC+4.
- if_id_valid  out  1  IF/ID holds a real instruction.

Behaviour:
- Reset (async, rst_n=0):
  - pc=RESET_PC, state=FETCH, imem_req=0 while in reset.
  - if_id_instr=NOP_INSTR, if_id_pc4=0, if_id_valid=0, hold buffer empty.
- redirect = branch_taken | jump_taken. Target = branch_dir if branch_taken, else jump_dir; branch wins because it is the older instruction.
- Redirect overrides stall.
- PC arithmetic is 32-bit modulo: 32'hFFFF_FFFC+4 wraps to 0. Bits [1:0] are not checked or masked.
- States: FETCH, HOLD, DISCARD.
- FETCH:
  - imem_req=1, imem_addr=pc.
  - redirect (any imem_ready): pc<=target; IF/ID flushed (valid=0, instr=NOP_INSTR). If imem_ready=1, the returned word is dropped and state stays FETCH. If imem_ready=0, go DISCARD and remember the old address in req_addr.
  - imem_ready & !stall: if_id_instr<=imem_rdata, if_id_pc4<=pc+4, if_id_valid<=1, pc<=pc+4.
  - imem_ready & stall: word and pc+4 go into the hold buffer; IF/ID and pc unchanged; go HOLD.
  - !imem_ready & !stall & !redirect: bubble, if_id_valid<=0, instr<=NOP_INSTR.
  - !imem_ready & stall: IF/ID held.
- HOLD:
  - imem_req=0; IF/ID held while stall=1.
  - stall=0: hold buffer moves to IF/ID (valid=1), pc<=pc+4, go FETCH.
  - redirect: hold buffer discarded, IF/ID flushed, pc<=target, go FETCH.
- DISCARD:
  - imem_req=1, imem_addr=req_addr (old address kept stable per handshake rule); IF/ID valid=0.
  - On imem_ready: data dropped, go FETCH at pc.
  - A further redirect here only updates pc (newest target wins); state stays DISCARD.
- Latency: issue at cycle N with imem_ready in N gives IF/ID valid at edge N+1. Peak throughput is one instruction per cycle.
- Outputs are registered. imem_req and imem_addr are decoded from state and pc/req_addr only; there is no combinational path from stall or redirect inputs.

Test Plan:
- Reset then release, imem_ready=1 every cycle, rdata=address-tagged words -> imem_addr 0,4,8,C; if_id_pc4 4,8,C,10; if_id_valid=1 from the first edge after the first request.
- stall=1 for 3 cycles at pc=8 with ready=1 -> word@8 goes to hold buffer, imem_req=0, IF/ID holds word@4. After stall drops, IF/ID=word@8 with pc4=C, pc=C.
- jump_taken=1, jump_dir=32'h0000_0400, with ready=1 at pc=10 -> word@10 dropped, IF/ID valid=0 next cycle, next imem_addr=400, then if_id_pc4=404.
- branch_taken (branch_dir=200) and jump_taken (jump_dir=400) asserted together -> pc=200.
- Redirect to 300 while the fetch of 20 is pending (ready=0 for 2 more cycles) -> imem_addr stays 20 until ready, data dropped, next request addr=300, no valid IF/ID in between.
- Assert rst_n=0 mid-HOLD with stall=1 -> immediate pc=RESET_PC, valid=0, hold buffer cleared, imem_req=0.
- pc=FFFF_FFFC with a fetch completing and stall=0 -> pc wraps to 0000_0000 and if_id_pc4=0.
